range_seq_driver: RTL and testbench

Producer side of the go/finish sample-stream protocol consumed by the range-finder datapath. The block buffers up to DEPTH samples loaded by a host, then drives them out as one framed burst: go with the first sample, one sample per cycle, then a one-cycle finish strobe. It captures the returned range and reports it to the host. It sits between host/test logic and the range finder, driving that block's data/go/finish inputs and sampling its range output.

---
 rtl/range_seq_if.sv | 29 ++
 rtl/range_seq_driver.sv | 137 +++++++++++++
 tb/tb_range_seq_driver.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/range_seq_if.sv
// Bundle between the burst driver, its host and the range-finder consumer.
// Handshake: a sample moves on any clock edge where load_valid && load_ready are both high.
interface range_seq_if #(
  parameter int W = 10
);
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         clear_buf;
  logic         start;
  logic [W-1:0] data_out;
  logic         go;
  logic         finish;
  logic [W-1:0] range_in;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         mismatch;

  modport master (
    output load_valid, load_data, clear_buf, start, range_in,
    input  load_ready, data_out, go, finish, busy, result, result_valid, mismatch
  );

  modport slave (
    input  load_valid, load_data, clear_buf, start, range_in,
    output load_ready, data_out, go, finish, busy, result, result_valid, mismatch
  );
endinterface

// File: rtl/range_seq_driver.sv
// Buffers up to DEPTH host samples and replays them as one go/finish framed burst, then captures the range.
// Optional self-check of the returned range is compiled in with RANGE_SEQ_CHECK_EN.
module range_seq_driver #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  range_seq_if.slave    io_bus,
  output logic [1:0]    o_state
);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUF_N = 1 << AW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FIN, S_CAPT} state_t;

  state_t        r_state;
  logic [W-1:0]  r_buf [0:BUF_N-1];
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_idx;
  logic [W-1:0]  r_data;
  logic          r_go;
  logic          r_fin;
  logic          r_busy;
  logic [W-1:0]  r_result;
  logic          r_rv;
`ifdef RANGE_SEQ_CHECK_EN
  logic [W-1:0]  r_min;
  logic [W-1:0]  r_max;
  logic          r_mm;
`endif

  logic          w_load_ready;
  logic          w_wr;
  logic          w_start_ok;
  logic [W-1:0]  w_rd;

  assign w_load_ready = !r_busy && (r_count < DEPTH_C);
  assign w_wr         = io_bus.load_valid && w_load_ready;
  // clear_buf wins over start so a burst never launches on a buffer being emptied
  assign w_start_ok   = (r_state == S_IDLE) && io_bus.start && (r_count != '0) && !io_bus.clear_buf;
  assign w_rd         = r_buf[r_idx[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_wptr   <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_go     <= 1'b0;
      r_fin    <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
      r_rv     <= 1'b0;
      for (int k = 0; k < BUF_N; k++) r_buf[k] <= '0;
`ifdef RANGE_SEQ_CHECK_EN
      r_min    <= '0;
      r_max    <= '0;
      r_mm     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.clear_buf) begin
            r_count <= '0;
            r_wptr  <= '0;
          end else if (w_wr) begin
            r_buf[r_wptr[AW-1:0]] <= io_bus.load_data;
            r_wptr  <= r_wptr + ONE;
            r_count <= r_count + ONE;
          end
          if (w_start_ok) begin
            r_state <= S_SEND;
            r_busy  <= 1'b1;
            r_go    <= 1'b1;
            r_data  <= r_buf[0];
            r_idx   <= ONE;
            r_rv    <= 1'b0;
`ifdef RANGE_SEQ_CHECK_EN
            r_min   <= r_buf[0];
            r_max   <= r_buf[0];
            r_mm    <= 1'b0;
`endif
          end
        end
        S_SEND: begin
          r_go <= 1'b0;
          if (r_idx == r_count) begin
            r_state <= S_FIN;
            r_fin   <= 1'b1;
            r_data  <= '0;
          end else begin
            r_data <= w_rd;
            r_idx  <= r_idx + ONE;
`ifdef RANGE_SEQ_CHECK_EN
            if (w_rd < r_min) r_min <= w_rd;
            if (w_rd > r_max) r_max <= w_rd;
`endif
          end
        end
        S_FIN: begin
          r_fin   <= 1'b0;
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_result <= io_bus.range_in;
          r_rv     <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
`ifdef RANGE_SEQ_CHECK_EN
          r_mm     <= (io_bus.range_in != (r_max - r_min));
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.load_ready   = w_load_ready;
  assign io_bus.data_out     = r_data;
  assign io_bus.go           = r_go;
  assign io_bus.finish       = r_fin;
  assign io_bus.busy         = r_busy;
  assign io_bus.result       = r_result;
  assign io_bus.result_valid = r_rv;
`ifdef RANGE_SEQ_CHECK_EN
  assign io_bus.mismatch     = r_mm;
`else
  assign io_bus.mismatch     = 1'b0;
`endif
  assign o_state = r_state;
endmodule

// File: tb/tb_range_seq_driver.sv
// Directed bench for range_seq_driver with a go/finish consumer model driving range_in.
module tb_range_seq_driver;
  localparam int W     = 10;
  localparam int DEPTH = 8;
`ifdef RANGE_SEQ_CHECK_EN
  localparam logic CHK_MM = 1'b1;
`else
  localparam logic CHK_MM = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  range_seq_if #(.W(W)) bus();
  logic [1:0] dut_state;

  range_seq_driver #(.W(W), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .io_bus  (bus),
    .o_state (dut_state)
  );

  // consumer model: min/max over the framed samples, range = max - min
  logic [W-1:0] c_min = '0;
  logic [W-1:0] c_max = '0;
  logic         c_act = 1'b0;
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;
  assign bus.range_in = force_en ? force_val : (c_max - c_min);

  always @(negedge clk) begin
    if (rst) begin
      c_act <= 1'b0;
    end else if (bus.go && !bus.finish) begin
      c_min <= bus.data_out;
      c_max <= bus.data_out;
      c_act <= 1'b1;
    end else if (bus.finish) begin
      c_act <= 1'b0;
    end else if (c_act) begin
      if (bus.data_out < c_min) c_min <= bus.data_out;
      if (bus.data_out > c_max) c_max <= bus.data_out;
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic load_one(input logic [W-1:0] v);
    bus.load_valid = 1'b1;
    bus.load_data  = v;
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic load_push(input logic [W-1:0] v);
    load_one(v);
    exp_q.push_back(v);
  endtask

  task automatic do_clear();
    bus.clear_buf = 1'b1;
    @(negedge clk);
    bus.clear_buf = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_burst(input string tag, input logic [W-1:0] exp_rng, input logic exp_mm);
    int n;
    n = exp_q.size();
    pulse_start();
    check_val({tag, "_rv_clr"}, bus.result_valid, 0);
    check_val({tag, "_mm_clr"}, bus.mismatch, 0);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check_val({tag, "_data"}, bus.data_out, e);
      check_val({tag, "_go"}, bus.go, (i == 0) ? 1 : 0);
      check_val({tag, "_fin_lo"}, bus.finish, 0);
      check_val({tag, "_busy"}, bus.busy, 1);
      check_val({tag, "_ld_blk"}, bus.load_ready, 0);
      @(negedge clk);
    end
    check_val({tag, "_fin"}, bus.finish, 1);
    check_val({tag, "_fin_go"}, bus.go, 0);
    check_val({tag, "_fin_data"}, bus.data_out, 0);
    @(negedge clk);
    check_val({tag, "_capt_busy"}, bus.busy, 1);
    check_val({tag, "_capt_fin"}, bus.finish, 0);
    check_val({tag, "_capt_rv"}, bus.result_valid, 0);
    @(negedge clk);
    check_val({tag, "_done_busy"}, bus.busy, 0);
    check_val({tag, "_rv"}, bus.result_valid, 1);
    check_val({tag, "_result"}, bus.result, exp_rng);
    check_val({tag, "_mm"}, bus.mismatch, exp_mm);
    check_val({tag, "_state"}, dut_state, 0);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.clear_buf  = 1'b0;
    bus.start      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_val("rst_ld_rdy", bus.load_ready, 1);
    check_val("rst_data", bus.data_out, 0);
    check_val("rst_go", bus.go, 0);
    check_val("rst_fin", bus.finish, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_result", bus.result, 0);
    check_val("rst_rv", bus.result_valid, 0);
    check_val("rst_mm", bus.mismatch, 0);
    check_val("rst_state", dut_state, 0);

    // basic burst, then a back-to-back replay of the same buffer
    load_push(10'd5); load_push(10'd9); load_push(10'd2); load_push(10'd7);
    run_burst("b4", 10'd7, 1'b0);
    exp_q.push_back(10'd5); exp_q.push_back(10'd9); exp_q.push_back(10'd2); exp_q.push_back(10'd7);
    run_burst("replay", 10'd7, 1'b0);

    // consumer returns a wrong range
    force_en  = 1'b1;
    force_val = 10'd3;
    exp_q.push_back(10'd5); exp_q.push_back(10'd9); exp_q.push_back(10'd2); exp_q.push_back(10'd7);
    run_burst("forced", 10'd3, CHK_MM);
    force_en  = 1'b0;
    exp_q.push_back(10'd5); exp_q.push_back(10'd9); exp_q.push_back(10'd2); exp_q.push_back(10'd7);
    run_burst("after_forced", 10'd7, 1'b0);

    // fill to DEPTH and hold a 9th offer
    do_clear();
    load_push(10'd10); load_push(10'd200); load_push(10'd3); load_push(10'd50);
    load_push(10'd1023); load_push(10'd0); load_push(10'd77); load_push(10'd512);
    bus.load_valid = 1'b1;
    bus.load_data  = 10'd99;
    check_val("full_ld_rdy", bus.load_ready, 0);
    @(negedge clk);
    check_val("full_ld_rdy2", bus.load_ready, 0);
    bus.load_valid = 1'b0;
    run_burst("full8", 10'd1023, 1'b0);

    // reset in the 2nd SEND cycle of a 4-sample burst
    do_clear();
    load_one(10'd11); load_one(10'd22); load_one(10'd33); load_one(10'd44);
    pulse_start();
    @(negedge clk);
    check_val("mid_pre_data", bus.data_out, 22);
    #1 rst = 1'b1;
    #1;
    check_val("mid_go", bus.go, 0);
    check_val("mid_fin", bus.finish, 0);
    check_val("mid_data", bus.data_out, 0);
    check_val("mid_ld_rdy", bus.load_ready, 1);
    check_val("mid_rv", bus.result_valid, 0);
    check_val("mid_result", bus.result, 0);
    check_val("mid_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    check_val("post_rst_busy", bus.busy, 0);
    check_val("post_rst_go", bus.go, 0);
    @(negedge clk);
    check_val("post_rst_busy2", bus.busy, 0);

    // single sample
    load_push(10'd300);
    run_burst("single", 10'd0, 1'b0);

    // start with an empty buffer
    do_clear();
    pulse_start();
    check_val("empty_busy", bus.busy, 0);
    check_val("empty_go", bus.go, 0);
    @(negedge clk);
    check_val("empty_busy2", bus.busy, 0);
    check_val("empty_fin", bus.finish, 0);
    load_one(10'd1);
    do_clear();
    pulse_start();
    check_val("cleared_busy", bus.busy, 0);
    check_val("cleared_go", bus.go, 0);
    @(negedge clk);
    check_val("cleared_busy2", bus.busy, 0);
    check_val("cleared_fin", bus.finish, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
